// File: rtl/game_pkg.sv
// Shared definitions for the asteroid game controller:
// lane count, game state encoding, BCD digit type and a lane popcount helper.
package game_pkg;

    localparam int NUM_LANES = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    function automatic logic [2:0] popcnt5(input logic [NUM_LANES-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score accumulator, +0..5 per cycle, saturating at 99.
// Ports: clk, rst_n, i_clr (sync clear), i_en, i_inc (0..5), o_lo/o_hi digits.
module bcd_score_counter
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [2:0] i_inc,
    output bcd_t       o_lo,
    output bcd_t       o_hi
);

    bcd_t       r_lo;
    bcd_t       r_hi;
    logic [4:0] w_lo_sum;
    logic       w_carry;

    assign w_lo_sum = {1'b0, r_lo} + {2'b00, i_inc};
    assign w_carry  = (w_lo_sum >= 5'd10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo <= 4'd0;
            r_hi <= 4'd0;
        end else if (i_clr) begin
            r_lo <= 4'd0;
            r_hi <= 4'd0;
        end else if (i_en) begin
            // A carry out of the tens digit pins the score at 99.
            if (w_carry && r_hi == 4'd9) begin
                r_lo <= 4'd9;
                r_hi <= 4'd9;
            end else if (w_carry) begin
                r_lo <= 4'(w_lo_sum - 5'd10);
                r_hi <= r_hi + 4'd1;
            end else begin
                r_lo <= w_lo_sum[3:0];
            end
        end
    end

    assign o_lo = r_lo;
    assign o_hi = r_hi;

endmodule

// File: rtl/asteroid_wave_scheduler.sv
// Game-level controller: IDLE/PLAY/GAME_OVER, paced random lane spawning,
// BCD score, difficulty level and lives. Inputs: tick, start, lane_busy/destroyed/impact.
// Outputs: spawn (one-hot pulse), speed_level, score_lo/hi, lives, playing, game_over.
module asteroid_wave_scheduler
    import game_pkg::*;
#(
    parameter int         SPAWN_BASE  = 90,
    parameter int         SPAWN_STEP  = 10,
    parameter int         SPAWN_MIN   = 20,
    parameter int         LEVEL_STEP  = 5,
    parameter int         START_LIVES = 3,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 start,
    input  logic [NUM_LANES-1:0] lane_busy,
    input  logic [NUM_LANES-1:0] lane_destroyed,
    input  logic [NUM_LANES-1:0] lane_impact,
    output logic [NUM_LANES-1:0] spawn,
    output logic [2:0]           speed_level,
    output logic [3:0]           score_lo,
    output logic [3:0]           score_hi,
    output logic [1:0]           lives,
    output logic                 playing,
    output logic                 game_over
);

    localparam int TW = $clog2(SPAWN_BASE + 2);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_LANES-1:0] r_spawn;
    logic [2:0]           r_level;
    logic [1:0]           r_lives;
    logic [TW-1:0]        r_timer;
    logic [3:0]           r_kills;
    logic [7:0]           r_lfsr;
    logic                 r_playing;
    logic                 r_over;

    logic                 w_in_play;
    logic                 w_start_game;
    logic [2:0]           w_kill_inc;
    logic [2:0]           w_hit;
    logic [1:0]           w_lives_nxt;
    logic [3:0]           w_ksum;
    logic [TW-1:0]        w_interval;
    logic [TW-1:0]        w_tnext;
    logic                 w_attempt;
    logic                 w_fb;
    logic [2:0]           w_cand;
    logic [3:0]           w_idx;
    logic                 w_found;
    logic [NUM_LANES-1:0] w_pick;

    assign w_in_play    = (r_state == S_PLAY);
    assign w_start_game = start && !w_in_play;
    assign w_kill_inc   = popcnt5(lane_destroyed);
    // A lane destroyed in the same cycle it impacts is not a lost life.
    assign w_hit        = popcnt5(lane_impact & ~lane_destroyed);
    assign w_lives_nxt  = (w_hit >= {1'b0, r_lives}) ? 2'd0 : r_lives - w_hit[1:0];
    assign w_ksum       = r_kills + {1'b0, w_kill_inc};
    assign w_tnext      = r_timer + TW'(1);
    assign w_fb         = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_cand       = (r_lfsr[2:0] >= 3'd5) ? r_lfsr[2:0] - 3'd5 : r_lfsr[2:0];

    always_comb begin
        if (int'(r_level) * SPAWN_STEP >= SPAWN_BASE - SPAWN_MIN)
            w_interval = TW'(SPAWN_MIN);
        else
            w_interval = TW'(SPAWN_BASE - int'(r_level) * SPAWN_STEP);
    end

    // Comparing the post-increment value makes the Nth tick the expiring one;
    // a blocked attempt leaves the timer alone so every later tick retries.
    assign w_attempt = w_in_play && tick && (w_tnext >= w_interval);

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 4'd0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_idx = {1'b0, w_cand} + 4'(k);
            if (w_idx >= 4'(NUM_LANES))
                w_idx = w_idx - 4'(NUM_LANES);
            if (!w_found && !lane_busy[w_idx[2:0]]) begin
                w_found              = 1'b1;
                w_pick[w_idx[2:0]]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_PLAY;
            S_PLAY:  if (w_lives_nxt == 2'd0) w_state_nxt = S_OVER;
            S_OVER:  if (start) w_state_nxt = S_PLAY;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spawn   <= '0;
            r_level   <= 3'd0;
            r_lives   <= 2'(START_LIVES);
            r_timer   <= '0;
            r_kills   <= 4'd0;
            r_lfsr    <= LFSR_SEED;
            r_playing <= 1'b0;
            r_over    <= 1'b0;
        end else begin
            r_spawn   <= '0;
            r_playing <= (w_state_nxt == S_PLAY);
            r_over    <= (w_state_nxt == S_OVER);
            if (w_start_game) begin
                r_level <= 3'd0;
                r_kills <= 4'd0;
                r_timer <= '0;
                r_lives <= 2'(START_LIVES);
            end else if (w_in_play) begin
                r_lfsr  <= {r_lfsr[6:0], w_fb};
                r_lives <= w_lives_nxt;
                if (w_ksum >= 4'(LEVEL_STEP)) begin
                    r_kills <= w_ksum - 4'(LEVEL_STEP);
                    if (r_level != 3'd7)
                        r_level <= r_level + 3'd1;
                end else begin
                    r_kills <= w_ksum;
                end
                if (w_attempt) begin
                    if (w_found) begin
                        r_timer <= '0;
                        // No launch on the edge that ends the game.
                        if (w_lives_nxt != 2'd0)
                            r_spawn <= w_pick;
                    end
                end else if (tick) begin
                    r_timer <= w_tnext;
                end
            end
        end
    end

    bcd_score_counter u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_start_game),
        .i_en  (w_in_play),
        .i_inc (w_kill_inc),
        .o_lo  (score_lo),
        .o_hi  (score_hi)
    );

    assign spawn       = r_spawn;
    assign speed_level = r_level;
    assign lives       = r_lives;
    assign playing     = r_playing;
    assign game_over   = r_over;

endmodule

// File: tb/tb_asteroid_wave_scheduler.sv
// Directed self-checking bench for asteroid_wave_scheduler.
// Walks reset, spawn pacing, blocked lanes, scoring, lives and mid-game reset.
module tb_asteroid_wave_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       start;
    logic [4:0] lane_busy;
    logic [4:0] lane_destroyed;
    logic [4:0] lane_impact;
    logic [4:0] spawn;
    logic [2:0] speed_level;
    logic [3:0] score_lo;
    logic [3:0] score_hi;
    logic [1:0] lives;
    logic       playing;
    logic       game_over;

    int n_checks = 0;
    int n_err    = 0;
    int spawn_cnt = 0;

    asteroid_wave_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick           (tick),
        .start          (start),
        .lane_busy      (lane_busy),
        .lane_destroyed (lane_destroyed),
        .lane_impact    (lane_impact),
        .spawn          (spawn),
        .speed_level    (speed_level),
        .score_lo       (score_lo),
        .score_hi       (score_hi),
        .lives          (lives),
        .playing        (playing),
        .game_over      (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && spawn != 5'd0) begin
            spawn_cnt++;
            chk("spawn_onehot", {15'd0, $onehot(spawn)}, 16'd1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
    endtask

    task automatic one_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic kill(input logic [4:0] d);
        lane_destroyed = d;
        cyc();
        lane_destroyed = 5'd0;
    endtask

    task automatic hit(input logic [4:0] m);
        lane_impact = m;
        cyc();
        lane_impact = 5'd0;
    endtask

    task automatic press_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic chk_score(input string tag, input logic [7:0] bcd);
        chk(tag, {8'd0, score_hi, score_lo}, {8'd0, bcd});
    endtask

    initial begin
        rst_n = 1'b0;
        tick = 1'b0;
        start = 1'b0;
        lane_busy = 5'd0;
        lane_destroyed = 5'd0;
        lane_impact = 5'd0;
        repeat (2) cyc();
        chk("rst_spawn", 16'(spawn), 16'd0);
        chk("rst_level", 16'(speed_level), 16'd0);
        chk_score("rst_score", 8'h00);
        chk("rst_lives", 16'(lives), 16'd3);
        chk("rst_playing", 16'(playing), 16'd0);
        chk("rst_over", 16'(game_over), 16'd0);
        chk("rst_lfsr", 16'(dut.r_lfsr), 16'h00A5);
        rst_n = 1'b1;
        cyc();
        chk("idle_playing", 16'(playing), 16'd0);

        press_start();
        chk("start_playing", 16'(playing), 16'd1);
        do_ticks(89);
        chk("no_spawn_89", 16'(spawn_cnt), 16'd0);
        one_tick();
        chk("spawn_at_90", {15'd0, spawn != 5'd0}, 16'd1);
        cyc();
        chk("spawn_1cyc", 16'(spawn), 16'd0);
        do_ticks(89);
        chk("timer_restart", 16'(spawn_cnt), 16'd1);

        lane_busy = 5'h1F;
        do_ticks(11);
        chk("all_busy_hold", 16'(spawn_cnt), 16'd1);
        lane_busy = 5'b11011;
        one_tick();
        chk("spawn_lane2", 16'(spawn), 16'b00100);
        lane_busy = 5'd0;
        cyc();

        lane_destroyed = 5'b01000;
        lane_impact = 5'b01000;
        cyc();
        lane_destroyed = 5'd0;
        lane_impact = 5'd0;
        chk_score("same_lane_score", 8'h01);
        chk("same_lane_lives", 16'(lives), 16'd3);

        kill(5'b00011);
        chk_score("score_03", 8'h03);
        chk("level_0", 16'(speed_level), 16'd0);
        kill(5'b00011);
        chk_score("score_05", 8'h05);
        chk("level_1", 16'(speed_level), 16'd1);
        do_ticks(79);
        chk("no_spawn_79", 16'(spawn_cnt), 16'd2);
        one_tick();
        chk("spawn_at_80", {15'd0, spawn != 5'd0}, 16'd1);
        cyc();

        for (int i = 0; i < 18; i++) kill(5'b11111);
        chk_score("score_95", 8'h95);
        kill(5'b00111);
        chk_score("score_98", 8'h98);
        kill(5'b10101);
        chk_score("score_sat99", 8'h99);
        chk("level_sat7", 16'(speed_level), 16'd7);

        hit(5'b00001);
        chk("lives_2", 16'(lives), 16'd2);
        hit(5'b00100);
        chk("lives_1", 16'(lives), 16'd1);
        chk("still_playing", 16'(playing), 16'd1);
        hit(5'b10000);
        chk("lives_0", 16'(lives), 16'd0);
        chk("over_high", 16'(game_over), 16'd1);
        chk("over_not_play", 16'(playing), 16'd0);
        cyc();
        do_ticks(25);
        chk("over_no_spawn", 16'(spawn_cnt), 16'd3);
        kill(5'b11111);
        chk_score("over_score_hold", 8'h99);

        press_start();
        chk("restart_playing", 16'(playing), 16'd1);
        chk("restart_over", 16'(game_over), 16'd0);
        chk_score("restart_score", 8'h00);
        chk("restart_lives", 16'(lives), 16'd3);
        chk("restart_level", 16'(speed_level), 16'd0);
        do_ticks(89);
        chk("restart_no_spawn", 16'(spawn_cnt), 16'd3);
        one_tick();
        chk("restart_spawn90", {15'd0, spawn != 5'd0}, 16'd1);

        rst_n = 1'b0;
        #1;
        chk("midrst_spawn", 16'(spawn), 16'd0);
        chk("midrst_playing", 16'(playing), 16'd0);
        chk_score("midrst_score", 8'h00);
        chk("midrst_lives", 16'(lives), 16'd3);
        chk("midrst_over", 16'(game_over), 16'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("midrst_lfsr", 16'(dut.r_lfsr), 16'h00A5);
        chk("midrst_idle", 16'(playing), 16'd0);
        do_ticks(3);
        chk("idle_no_spawn", 16'(spawn_cnt), 16'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
